// File: rtl/spi_sram_ctrl.sv
// rtl/spi_sram_ctrl.sv - byte-access SPI mode-0 controller for a 23LC512-class serial SRAM
// Sets byte mode after reset, then turns single-byte read/write requests into cmd+addr+data frames.
module spi_sram_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        init_done,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_div;
  logic [5:0]  r_bitcnt;
  logic [31:0] r_shift;
  logic [7:0]  r_rx;
  logic [7:0]  r_rdata;
  logic        r_is_read;
  logic        r_is_init;
  logic        r_sck;
  logic        r_cs_n;
  logic        r_done;
  logic        r_init_done;

  logic        w_div_zero;
  logic        w_accept;

  assign w_div_zero = (r_div == 8'd0);
  // Ready opens in the last gap cycle so a held req restarts the next frame with no extra bubble.
  assign ready      = r_init_done && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_div_zero));
  assign w_accept   = req && ready;

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign init_done = r_init_done;
  assign sck       = r_sck;
  assign cs_n      = r_cs_n;
  assign mosi      = r_shift[31];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_INIT;
      r_div       <= 8'd0;
      r_bitcnt    <= 6'd0;
      r_shift     <= 32'd0;
      r_rx        <= 8'd0;
      r_rdata     <= 8'd0;
      r_is_read   <= 1'b0;
      r_is_init   <= 1'b0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_done      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_state   <= S_SETUP;
          r_cs_n    <= 1'b0;
          r_div     <= DIV_LOAD;
          r_bitcnt  <= 6'd15;
          r_shift   <= {8'h01, 8'h00, 16'h0000};
          r_is_init <= 1'b1;
          r_is_read <= 1'b0;
        end
        S_IDLE, S_GAP: begin
          if (w_accept) begin
            r_state   <= S_SETUP;
            r_cs_n    <= 1'b0;
            r_div     <= DIV_LOAD;
            r_bitcnt  <= 6'd31;
            r_shift   <= we ? {8'h02, addr, wdata} : {8'h03, addr, 8'h00};
            r_is_init <= 1'b0;
            r_is_read <= !we;
          end else if (r_state == S_GAP) begin
            if (w_div_zero) r_state <= S_IDLE;
            else            r_div   <= r_div - 8'd1;
          end
        end
        S_SETUP: begin
          if (w_div_zero) begin
            r_state <= S_SHIFT;
            r_div   <= DIV_LOAD;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        S_SHIFT: begin
          if (!w_div_zero) begin
            r_div <= r_div - 8'd1;
          end else begin
            r_div <= DIV_LOAD;
            if (!r_sck) begin
              r_sck <= 1'b1;
              if (r_is_read && (r_bitcnt < 6'd8)) r_rx <= {r_rx[6:0], miso};
            end else begin
              r_sck    <= 1'b0;
              r_shift  <= {r_shift[30:0], 1'b0};
              r_bitcnt <= r_bitcnt - 6'd1;
              if (r_bitcnt == 6'd0) r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_div_zero) begin
            r_state <= S_GAP;
            r_cs_n  <= 1'b1;
            r_div   <= GAP_LOAD;
            if (r_is_init) begin
              r_init_done <= 1'b1;
            end else begin
              r_done <= 1'b1;
              if (r_is_read) r_rdata <= r_rx;
            end
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// tb/tb_spi_sram_ctrl.sv - directed and random checks of spi_sram_ctrl against an SRAM model
module tb_spi_sram_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        ready, done, init_done, sck, cs_n, mosi;
  logic [7:0]  rdata;
  logic        miso = 1'b0;

  spi_sram_ctrl #(.CLK_DIV(2), .CS_GAP(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .init_done(init_done),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int frames = 0;
  int t_fall = 0, t_rise = 0, last_low = 0, last_gap = 0;
  int s_cnt = 0, last_cnt = 0;
  logic [31:0] s_bits = 32'd0, last_frame = 32'd0;
  logic [7:0]  s_cmd = 8'd0, s_rbyte = 8'd0;
  logic [7:0]  sram [int];
  logic [7:0]  ref_mem [int];
  logic [7:0]  exp_rdata = 8'h00;
  int          exp_done = 0;

  always @(posedge HCLK) cyc++;
  always @(negedge HCLK) if (done === 1'b1) done_cnt++;

  // Serial SRAM slave: samples mosi on sck rise, drives miso on sck fall.
  always @(negedge cs_n) begin
    s_cnt = 0; s_bits = 32'd0; frames++;
    t_fall = cyc; last_gap = t_fall - t_rise;
  end
  always @(posedge cs_n) begin
    last_frame = s_bits; last_cnt = s_cnt;
    t_rise = cyc; last_low = t_rise - t_fall;
    if (s_cnt == 32 && s_bits[31:24] == 8'h02) sram[int'(s_bits[23:8])] = s_bits[7:0];
  end
  always @(posedge sck) if (cs_n === 1'b0) begin
    s_bits = {s_bits[30:0], mosi};
    s_cnt++;
    if (s_cnt == 24) begin
      s_cmd = s_bits[23:16];
      s_rbyte = sram.exists(int'(s_bits[15:0])) ? sram[int'(s_bits[15:0])] : 8'h00;
    end
  end
  always @(negedge sck) begin
    if (cs_n === 1'b0 && s_cnt >= 24 && s_cnt < 32 && s_cmd == 8'h03) miso = s_rbyte[7 - (s_cnt - 24)];
    else miso = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 400) begin @(negedge HCLK); n++; end
    check({tag, " init_done"}, 64'(init_done), 64'd1);
    check({tag, " init bits"}, 64'(last_cnt), 64'd16);
    check({tag, " init frame"}, 64'(last_frame[15:0]), 64'h0100);
    check({tag, " init cs_low"}, 64'(last_low), 64'd68);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
    check({tag, " ready"}, 64'(ready), 64'd1);
  endtask

  task automatic start_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin @(negedge HCLK); n++; end
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge HCLK);
    @(negedge HCLK);
    req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
  endtask

  task automatic finish_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                            input int n0, input string tag);
    int n = n0;
    logic [31:0] ef;
    ef = w ? {8'h02, a, d} : {8'h03, a, 8'h00};
    while (done !== 1'b1 && n < 400) begin @(negedge HCLK); n++; end
    check({tag, " latency"}, 64'(n), 64'd133);
    check({tag, " frame"}, 64'(last_frame), 64'(ef));
    check({tag, " bits"}, 64'(last_cnt), 64'd32);
    check({tag, " cs_low"}, 64'(last_low), 64'd132);
    if (w) ref_mem[int'(a)] = d;
    else   exp_rdata = ref_rd(a);
    check({tag, " rdata"}, 64'(rdata), 64'(exp_rdata));
    exp_done++;
    @(negedge HCLK);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d, input string tag);
    start_txn(w, a, d);
    finish_txn(w, a, d, 1, tag);
  endtask

  initial begin
    logic [15:0] pool [4];
    int n, fr, dc;
    pool[0] = 16'h0000; pool[1] = 16'h1234; pool[2] = 16'hFFFF; pool[3] = 16'h00FF;

    repeat (3) @(negedge HCLK);
    check("rst sck", 64'(sck), 64'd0);
    check("rst cs_n", 64'(cs_n), 64'd1);
    check("rst mosi", 64'(mosi), 64'd0);
    check("rst ready", 64'(ready), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    check("rst init_done", 64'(init_done), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("init starts", 64'(cs_n), 64'd0);
    wait_init("boot");
    check("boot no done", 64'(done_cnt), 64'd0);

    do_txn(1'b1, 16'h1234, 8'hA5, "wr1234");
    do_txn(1'b0, 16'h1234, 8'h00, "rd1234");

    // req held high across the gap: write then read the top address
    n = 0;
    while (ready !== 1'b1 && n < 400) begin @(negedge HCLK); n++; end
    req = 1'b1; we = 1'b1; addr = 16'hFFFF; wdata = 8'h3C;
    @(posedge HCLK);
    @(negedge HCLK);
    finish_txn(1'b1, 16'hFFFF, 8'h3C, 1, "b2b_wr");
    we = 1'b0;
    n = 0;
    while (cs_n !== 1'b0 && n < 10) begin @(negedge HCLK); n++; end
    req = 1'b0;
    check("b2b cs_gap", 64'(last_gap), 64'd2);
    finish_txn(1'b0, 16'hFFFF, 8'h00, 1, "b2b_rd");

    // req pulse while shifting must be ignored
    fr = frames;
    start_txn(1'b1, 16'h0040, 8'h5A);
    repeat (40) @(negedge HCLK);
    req = 1'b1; we = 1'b1; addr = 16'h0041; wdata = 8'hEE;
    @(negedge HCLK);
    req = 1'b0;
    finish_txn(1'b1, 16'h0040, 8'h5A, 42, "busy_wr");
    repeat (20) @(negedge HCLK);
    check("busy frames", 64'(frames - fr), 64'd1);
    do_txn(1'b0, 16'h0041, 8'h00, "busy_rd41");
    do_txn(1'b0, 16'h0040, 8'h00, "busy_rd40");

    // reset in the middle of a write
    start_txn(1'b1, 16'h1234, 8'h77);
    n = 0;
    while (s_cnt < 10 && n < 200) begin @(negedge HCLK); n++; end
    check("abort bit10", 64'(s_cnt), 64'd10);
    dc = done_cnt;
    #2 HRESET = 1'b1;
    #1;
    check("abort cs_n", 64'(cs_n), 64'd1);
    check("abort sck", 64'(sck), 64'd0);
    @(negedge HCLK);
    check("abort init_done", 64'(init_done), 64'd0);
    check("abort rdata", 64'(rdata), 64'd0);
    exp_rdata = 8'h00;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("reinit starts", 64'(cs_n), 64'd0);
    wait_init("reinit");
    check("abort no done", 64'(done_cnt - dc), 64'd0);
    do_txn(1'b0, 16'h1234, 8'h00, "abort_rd");

    for (int i = 0; i < 10; i++) begin
      logic       w;
      logic [15:0] a;
      logic [7:0]  d;
      w = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 3)];
      d = 8'($urandom);
      do_txn(w, a, d, $sformatf("rnd%0d", i));
    end

    check("done count", 64'(done_cnt), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sram_ctrl.md
# spi_sram_ctrl

Byte-access controller for the 23LC512-class serial SRAM that hangs off the SoC SPI pads (MSO/MSI/SCLK/SSn). It converts a single-requester byte read/write handshake from the bus-side logic into complete SPI mode-0 frames: command, 16-bit address, then one data byte. After reset it writes the SRAM mode register to byte mode. It owns the pads exclusively; no other master drives the SRAM.

## Interface
Parameters:
- CLK_DIV, default 2: SCK half-period in HCLK cycles. Legal range is 1..255.
- CS_GAP, default 2: minimum HCLK cycles SSn stays high between frames. Legal range is 1..255.

Ports:
- HCLK  in  1  system clock; all logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req  in  1  transaction request.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  SRAM byte address.
- wdata  in  8  write data.
- ready  out  1  controller can accept req this cycle.
- done  out  1  one-cycle pulse at end of a transaction.
- rdata  out  8  read data; valid from done and held until the next read's done.
- init_done  out  1  mode-register write is complete.
- sck  out  1  SPI clock; idles low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

## Operation
- Handshake:
  - A transfer is accepted on any HCLK edge where req && ready.
  - we, addr and wdata are captured at that edge, and ready drops the next cycle.
  - req while ready=0 is ignored; there is no queue.
- States:
  - INIT: load the WRMR frame. Always entered from reset.
  - IDLE: ready=1 only if init_done=1.
  - SETUP, SHIFT, HOLD: the frame itself.
  - GAP: SSn-high recovery.
  - Transitions: INIT→SETUP; IDLE→SETUP on accept; SETUP→SHIFT; SHIFT→HOLD after the last bit; HOLD→GAP; GAP→IDLE.
- Frame contents, MSB first:
  - Init frame: 0x01, 0x00 (16 bits).
  - Read frame: 0x03, addr[15:8], addr[7:0], 8 dummy bits (32 bits).
  - Write frame: 0x02, addr[15:8], addr[7:0], wdata (32 bits).
  - During read dummy bits, mosi = 0.
- Bit counter: 6 bits. Loaded with 15 for the init frame and 31 otherwise; decrements on each SCK falling edge; SHIFT exits when it wraps from 0.
- Read capture:
  - miso is shifted into a receive register on each SCK rising edge of bits 7..0 of the data byte.
  - rdata is updated from that register at done.
  - Writes never change rdata.
- After the init frame, init_done goes to 1 and stays there until reset. The init frame produces no done pulse.

## Timing
- Reset values: sck=0, cs_n=1, mosi=0, ready=0, done=0, rdata=0x00, init_done=0. The state goes to INIT.
- First frame: the INIT frame starts in the first cycle after HRESET deasserts.
- SETUP: cs_n falls on the edge that enters SETUP, and mosi shows the frame MSB on that same edge. SETUP lasts CLK_DIV cycles.
- SHIFT, per bit (2*CLK_DIV cycles):
  - sck is low for CLK_DIV cycles while mosi is stable.
  - sck then rises; the slave samples mosi and the controller samples miso on this edge.
  - sck stays high for CLK_DIV cycles, then falls.
  - mosi moves to the next bit on the same edge that sck falls.
- HOLD: after the final falling edge, sck=0 and cs_n stays low for CLK_DIV cycles. cs_n then rises and done pulses on that same edge.
- GAP: cs_n stays high for CS_GAP cycles, then ready=1.
- Latency, accept edge to done: 1 + CLK_DIV + 64*CLK_DIV + CLK_DIV cycles. With the default CLK_DIV=2 this is 133 cycles.
- Accept-to-accept period: latency + CS_GAP.
- req held high across GAP: re-accepted on the first cycle that ready=1. There is no bubble beyond CS_GAP.
- Reset mid-frame: asynchronously forces cs_n=1 and sck=0 and aborts the frame. No done pulse. init_done clears and the INIT frame reruns.
- CLK_DIV=1: sck = HCLK/2. All rules above still hold.

## Test plan
- Reset release with CLK_DIV=2: exactly 16 sck rising edges carrying 0x0100. cs_n stays low for 2+64+2 cycles. Then init_done=1 and ready=1, with done never asserted.
- Write addr=0x1234, wdata=0xA5: mosi sampled on sck rising edges equals 0x021234A5. done arrives 133 cycles after accept. rdata is unchanged.
- Read addr=0x1234 against the SRAM model after that write: mosi shows 0x031234 followed by zeros. rdata=0xA5 at done.
- Back-to-back with req held high, writing 0xFFFF=0x3C then reading 0xFFFF: cs_n is high for exactly CS_GAP=2 cycles between frames. The read returns 0x3C.
- req pulsed while busy (during SHIFT): ignored. No extra frame is started, and captured addr/wdata are unaffected.
- HRESET asserted at bit 10 of a write: cs_n=1 and sck=0 in the same cycle. No done pulse. The INIT frame reruns, and a later read of that address returns the old data.
